// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ack handshake,
// holds one instruction for decode and drops fetches made stale by redirects.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        inst_valid,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        misalign,
  output logic [31:0] fetch_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  localparam logic [1:0] DROP = 2'd3;

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] inst_r;
  logic [31:0] inst_r_next;
  logic        inst_valid_next;
  logic [31:0] drop_addr;
  logic [31:0] drop_addr_next;
  logic [31:0] fetch_count_next;
  logic [31:0] target;

  assign target    = {redirect_pc[31:2], 2'b00};
  assign imem_req  = (state == REQ) || (state == DROP);
  // DROP keeps presenting the address of the abandoned request until it completes
  assign imem_addr = (state == DROP) ? drop_addr : pc;
  assign inst      = inst_valid ? inst_r : NOP_INST;
  assign pc_out    = pc;
  assign pc_plus4  = pc + 32'd4;

  always_comb begin
    state_next       = state;
    pc_next          = pc;
    inst_r_next      = inst_r;
    inst_valid_next  = inst_valid;
    drop_addr_next   = drop_addr;
    fetch_count_next = fetch_count;
    case (state)
      IDLE: begin
        state_next = REQ;
        if (redirect) begin
          pc_next = target;
        end else begin
          pc_next = pc;
        end
      end
      REQ: begin
        if (imem_ack && !redirect) begin
          inst_r_next     = imem_rdata;
          inst_valid_next = 1'b1;
          state_next      = HOLD;
        end else if (redirect) begin
          pc_next = target;
          if (imem_ack) begin
            state_next = REQ;
          end else begin
            drop_addr_next = pc;
            state_next     = DROP;
          end
        end else begin
          state_next = REQ;
        end
      end
      HOLD: begin
        // redirect outranks stall and is not a consumed instruction
        if (redirect) begin
          pc_next         = target;
          inst_valid_next = 1'b0;
          state_next      = REQ;
        end else if (!stall) begin
          pc_next          = pc + 32'd4;
          inst_valid_next  = 1'b0;
          fetch_count_next = fetch_count + 32'd1;
          state_next       = REQ;
        end else begin
          state_next = HOLD;
        end
      end
      DROP: begin
        if (redirect) begin
          pc_next = target;
        end else begin
          pc_next = pc;
        end
        if (imem_ack) begin
          state_next = REQ;
        end else begin
          state_next = DROP;
        end
      end
      default: begin
        state_next      = IDLE;
        inst_valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      inst_r      <= NOP_INST;
      inst_valid  <= 1'b0;
      drop_addr   <= RESET_PC;
      fetch_count <= 32'd0;
      misalign    <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      inst_r      <= inst_r_next;
      inst_valid  <= inst_valid_next;
      drop_addr   <= drop_addr_next;
      fetch_count <= fetch_count_next;
      misalign    <= redirect && (redirect_pc[1:0] != 2'b00);
    end
  end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch stage for the single-issue RISC-V core. Holds the program counter, issues word requests to instruction memory over a req/ack handshake, and presents one instruction at a time (with its PC) to the decode/control stage. Accepts PC redirects from branch/jump resolution and discards any in-flight fetch made stale by a redirect.

## Interface

- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP_INST, 32'h0000_0013, value driven on `inst` while no valid instruction is held (addi x0,x0,0)

- clk  in  1  core clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- imem_req  out  1  fetch request; held high until `imem_ack`
- imem_addr  out  32  word address of request; stable while `imem_req`=1
- imem_ack  in  1  memory completes request this cycle; `imem_rdata` valid
- imem_rdata  in  32  fetched instruction word
- inst  out  32  instruction to decode (opcode/func3/func7 fields taken from it)
- pc_out  out  32  PC of `inst`
- pc_plus4  out  32  `pc_out`+4, modulo 2^32 (link value for jal/jalr)
- inst_valid  out  1  `inst`/`pc_out` hold a valid instruction
- stall  in  1  decode cannot consume `inst` this cycle
- redirect  in  1  taken branch/jump; load `redirect_pc`
- redirect_pc  in  32  target address
- misalign  out  1  one-cycle pulse: accepted redirect had `redirect_pc[1:0]`≠0
- fetch_count  out  32  instructions consumed by decode since reset

## Operation

- States: IDLE, REQ, HOLD, DROP. Registers: `pc`, `inst_r`, `inst_valid`, `fetch_count`, `misalign`, state.
- `imem_req` = (state==REQ || state==DROP); `imem_addr` = `pc` in REQ, latched stale address in DROP.
- IDLE: entered at reset; next cycle -> REQ.
- REQ: if `imem_ack` and no `redirect`: `inst_r`<=`imem_rdata`, `inst_valid`<=1, -> HOLD. If `imem_ack` and `redirect`: data discarded, `pc`<=target, stay REQ. If `redirect` without ack: `pc`<=target, -> DROP (old request remains outstanding).
- DROP: `imem_req` stays high at old address until `imem_ack`; returned data discarded; -> REQ with current `pc`. Further redirects in DROP update `pc` (latest wins).
- HOLD: `inst_valid`=1. `redirect` (highest priority, overrides `stall`): `pc`<=target, `inst_valid`<=0, -> REQ, not counted. Else if `!stall`: `pc`<=`pc`+4, `inst_valid`<=0, `fetch_count`++, -> REQ. Else hold all.
- Redirect in IDLE: `pc`<=target, -> REQ.
- Target = {`redirect_pc`[31:2],2'b00}; `misalign`<=|`redirect_pc`[1:0] on any accepted redirect, else 0.
- `inst` = `inst_valid` ? `inst_r` : NOP_INST. `pc_out` = `pc`.
- All PC arithmetic 32-bit, wraps (0xFFFF_FFFC+4 = 0). `fetch_count` wraps at 2^32.

## Timing

- Reset values: state IDLE, `pc`=RESET_PC, `inst_valid`=0, `inst`=NOP_INST, `imem_req`=0, `misalign`=0, `fetch_count`=0. Reset asserted mid-transaction abandons it immediately; memory must tolerate `imem_req` dropping without ack.
- First `imem_req` in 2nd cycle after reset release.
- `imem_ack` in cycle n -> `inst_valid`=1 in cycle n+1. Ack allowed in same cycle `imem_req` rises.
- Throughput with single-cycle-ack memory, no stall: one instruction per 2 cycles (REQ, HOLD).
- Redirect effect visible on `imem_addr` next cycle (REQ) or after pending ack (DROP).
- `misalign` high exactly one cycle after the redirect cycle.

## Test plan

- Reset release, memory acks immediately with 0x00500093 at 0x0 -> `imem_addr`=0x0, then `inst`=0x00500093, `pc_out`=0, `pc_plus4`=4, next request at 0x4.
- Streaming 4 instructions, ack delay 3 cycles, no stall -> addresses 0,4,8,C; `fetch_count`=4; `inst`=NOP_INST whenever `inst_valid`=0.
- `stall` held 5 cycles in HOLD -> `inst`/`pc_out` unchanged, no `imem_req`, `fetch_count` unchanged; release -> advances by 4.
- Redirect to 0x100 while request at 0x8 outstanding (ack 2 cycles later, data 0xDEADBEEF) -> `imem_addr` stays 0x8 until ack, data never valid, next request at 0x100.
- Redirect to 0x203 coincident with ack, and redirect+stall in HOLD -> target 0x200, `misalign` pulses once, redirect wins over stall, `fetch_count` not incremented.
- Assert `rst` mid-DROP and with `pc`=0xFFFF_FFFC wrap case -> all outputs return to reset values asynchronously; from 0xFFFF_FFFC next fetch address is 0x0.
